// File: rtl/condicionador_sensores_if.sv
// Sensor conditioner bus: raw wall-sensor inputs plus filtered levels and status.
interface condicionador_sensores_if;
    logic       head_raw;
    logic       left_raw;
    logic       head;
    logic       left;
    logic       atualizado;
    logic [7:0] glitches;

    modport master (
        output head_raw, left_raw,
        input  head, left, atualizado, glitches
    );

    modport slave (
        input  head_raw, left_raw,
        output head, left, atualizado, glitches
    );
endinterface

// File: rtl/condicionador_sensores.sv
// Two-channel wall-sensor conditioner: 2-flop synchronizer, per-channel debounce FSM,
// shared update pulse and saturating glitch counter. All state updates on the falling edge.
module condicionador_sensores #(
    parameter int unsigned DEBOUNCE = 4
) (
    input logic                      clock,
    input logic                      reset,
    condicionador_sensores_if.slave  bus
);
    typedef enum logic {StEstavel, StConfirmando} state_e;

    localparam logic [7:0] CntLast = 8'(DEBOUNCE - 1);

    logic [1:0] raw;
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] filt_q, filt_d;
    logic [1:0] commit, reject;
    state_e     state_q [2];
    state_e     state_d [2];
    logic [7:0] cnt_q [2];
    logic [7:0] cnt_d [2];
    logic       atualizado_q, atualizado_d;
    logic [7:0] glitches_q, glitches_d;
    logic [8:0] glitch_sum;

    // Index 0 is the front (head) channel, index 1 the left channel.
    assign raw = {bus.left_raw, bus.head_raw};

    always_comb begin
        filt_d = filt_q;
        commit = '0;
        reject = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StEstavel: begin
                    if (sync2_q[i] != filt_q[i]) begin
                        state_d[i] = StConfirmando;
                        cnt_d[i]   = 8'd1;
                    end else begin
                        cnt_d[i] = 8'd0;
                    end
                end
                StConfirmando: begin
                    if (sync2_q[i] == filt_q[i]) begin
                        reject[i]  = 1'b1;
                        state_d[i] = StEstavel;
                        cnt_d[i]   = 8'd0;
                    end else if (cnt_q[i] == CntLast) begin
                        commit[i]  = 1'b1;
                        filt_d[i]  = sync2_q[i];
                        state_d[i] = StEstavel;
                        cnt_d[i]   = 8'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
                default: begin
                    state_d[i] = StEstavel;
                    cnt_d[i]   = 8'd0;
                end
            endcase
        end
    end

    // Both channels can reject on the same edge, so add up to two and clamp at 255.
    always_comb begin
        glitch_sum   = {1'b0, glitches_q} + {8'd0, reject[0]} + {8'd0, reject[1]};
        glitches_d   = glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
        atualizado_d = |commit;
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            filt_q       <= '0;
            atualizado_q <= 1'b0;
            glitches_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StEstavel;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            filt_q       <= filt_d;
            atualizado_q <= atualizado_d;
            glitches_q   <= glitches_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign bus.head       = filt_q[0];
    assign bus.left       = filt_q[1];
    assign bus.atualizado = atualizado_q;
    assign bus.glitches   = glitches_q;
endmodule

// File: tb/tb_condicionador_sensores.sv
// Directed bench for condicionador_sensores with DEBOUNCE=4; checks sampled 1 ns after each
// falling edge, inputs changed at the same point so they are stable before the next edge.
module tb_condicionador_sensores;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    condicionador_sensores_if sif ();

    condicionador_sensores #(.DEBOUNCE(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        sif.head_raw = 1'b0;
        sif.left_raw = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_head", 32'(sif.head), 0);
        check("rst_left", 32'(sif.left), 0);
        check("rst_atualizado", 32'(sif.atualizado), 0);
        check("rst_glitches", 32'(sif.glitches), 0);

        // Head rises: held from edge 1, visible after edge 6.
        reset = 1'b0;
        sif.head_raw = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("rise_head_early", 32'(sif.head), 0);
            check("rise_atu_early", 32'(sif.atualizado), 0);
        end
        tick();
        check("rise_head_e6", 32'(sif.head), 1);
        check("rise_atu_e6", 32'(sif.atualizado), 1);
        check("rise_glitches", 32'(sif.glitches), 0);
        tick();
        check("rise_atu_e7", 32'(sif.atualizado), 0);
        check("rise_head_e7", 32'(sif.head), 1);

        // Head falls six edges after raw goes low.
        sif.head_raw = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("fall_head_early", 32'(sif.head), 1);
        end
        tick();
        check("fall_head_e6", 32'(sif.head), 0);
        check("fall_atu_e6", 32'(sif.atualizado), 1);
        tick();
        check("fall_atu_e7", 32'(sif.atualizado), 0);

        // Two-sample pulse on left is rejected.
        sif.left_raw = 1'b1;
        tick();
        tick();
        sif.left_raw = 1'b0;
        check("glitch_left_0", 32'(sif.left), 0);
        for (int e = 3; e <= 10; e++) begin
            tick();
            check("glitch_left", 32'(sif.left), 0);
            check("glitch_atu", 32'(sif.atualizado), 0);
        end
        check("glitch_count1", 32'(sif.glitches), 1);

        // Both channels rise together: one shared pulse.
        sif.head_raw = 1'b1;
        sif.left_raw = 1'b1;
        for (int e = 1; e <= 5; e++) tick();
        check("both_head_e5", 32'(sif.head), 0);
        check("both_left_e5", 32'(sif.left), 0);
        tick();
        check("both_head_e6", 32'(sif.head), 1);
        check("both_left_e6", 32'(sif.left), 1);
        check("both_atu_e6", 32'(sif.atualizado), 1);
        tick();
        check("both_atu_e7", 32'(sif.atualizado), 0);
        check("both_glitches", 32'(sif.glitches), 1);

        // Reset mid-confirmation discards the pending rise.
        reset = 1'b1;
        sif.head_raw = 1'b0;
        sif.left_raw = 1'b0;
        tick();
        tick();
        check("rst2_head", 32'(sif.head), 0);
        check("rst2_left", 32'(sif.left), 0);
        check("rst2_glitches", 32'(sif.glitches), 0);
        reset = 1'b0;
        sif.head_raw = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_head_e4", 32'(sif.head), 0);
        reset = 1'b0;
        for (int e = 5; e <= 9; e++) begin
            tick();
            check("midrst_head_early", 32'(sif.head), 0);
        end
        tick();
        check("midrst_head_e10", 32'(sif.head), 1);
        check("midrst_atu_e10", 32'(sif.atualizado), 1);

        // Saturation: 127 double glitches reach 254, the 128th gives 255.
        reset = 1'b1;
        sif.head_raw = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("sat_start", 32'(sif.glitches), 0);
        for (int g = 0; g < 127; g++) begin
            sif.head_raw = 1'b1;
            sif.left_raw = 1'b1;
            tick();
            sif.head_raw = 1'b0;
            sif.left_raw = 1'b0;
            tick();
            tick();
            tick();
        end
        check("sat_254", 32'(sif.glitches), 254);
        check("sat_head_stays", 32'(sif.head), 0);
        check("sat_left_stays", 32'(sif.left), 0);
        sif.head_raw = 1'b1;
        sif.left_raw = 1'b1;
        tick();
        sif.head_raw = 1'b0;
        sif.left_raw = 1'b0;
        tick();
        tick();
        tick();
        check("sat_255", 32'(sif.glitches), 255);
        for (int g = 0; g < 3; g++) begin
            sif.left_raw = 1'b1;
            tick();
            sif.left_raw = 1'b0;
            tick();
            tick();
            tick();
            check("sat_hold", 32'(sif.glitches), 255);
        end
        check("sat_atu", 32'(sif.atualizado), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/condicionador_sensores.md
CONDICIONADOR_SENSORES -- requirements
Module: condicionador_sensores

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, meaning the number of consecutive samples a new level must hold before it is accepted; legal range 2..255.
REQ-002 Port clock, input, 1, meaning the single system clock; all state SHALL update on its falling edge.
REQ-003 Port reset, input, 1, meaning reset; it SHALL be synchronous and active-high.
REQ-004 Port head_raw, input, 1, meaning the raw front wall sensor; it is asynchronous and may bounce.
REQ-005 Port left_raw, input, 1, meaning the raw left wall sensor; it is asynchronous and may bounce.
REQ-006 Port head, output, 1, meaning the filtered front sensor level, which feeds the wall-following controller.
REQ-007 Port left, output, 1, meaning the filtered left sensor level, which feeds the wall-following controller.
REQ-008 Port atualizado, output, 1, meaning a one-cycle pulse that some filtered output changed.
REQ-009 Port glitches, output, 8, meaning the saturating count of rejected input glitches.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer; the second flop gives the synchronized level s_x.
REQ-011 Each channel SHALL have an independent FSM with two states, ESTAVEL and CONFIRMANDO, and an 8-bit counter cnt.
REQ-012 In ESTAVEL, if s_x differs from the filtered output: go to CONFIRMANDO with cnt=1. Otherwise stay in ESTAVEL with cnt=0.
REQ-013 In CONFIRMANDO, if s_x equals the filtered output: the glitch is rejected; go to ESTAVEL, cnt=0, and the filtered output is unchanged.
REQ-014 In CONFIRMANDO, if s_x still differs and cnt==DEBOUNCE-1: commit filtered<=s_x, go to ESTAVEL, cnt=0.
REQ-015 In CONFIRMANDO, if s_x still differs and cnt<DEBOUNCE-1: cnt<=cnt+1 and stay in CONFIRMANDO.
REQ-016 Latency: a raw level that is stable before falling edge N SHALL appear on the filtered output after falling edge N+DEBOUNCE+1, i.e. on the (DEBOUNCE+2)th edge counting N as the first.
REQ-017 A raw pulse shorter than DEBOUNCE samples after synchronization SHALL never change the filtered output.
REQ-018 atualizado SHALL be registered and go high on the same edge that commits either channel, for exactly one cycle.
REQ-019 If both channels commit on the same edge, atualizado SHALL produce a single pulse.
REQ-020 glitches SHALL add the number of channels that took the REQ-013 rejection on that edge (0, 1 or 2).
REQ-021 glitches SHALL saturate at 255; at 254 with two simultaneous rejections the result SHALL be 255.
REQ-022 Channels SHALL NOT interact, except through the shared atualizado and glitches outputs.
REQ-023 head and left SHALL be driven only from registers, with no combinational path from the raw inputs.

Reset
REQ-024 While reset=1 at a falling edge, the following SHALL clear to 0: synchronizer flops, head, left, cnt, atualizado and glitches.
REQ-025 While reset=1 at a falling edge, both FSMs SHALL go to ESTAVEL.
REQ-026 Reset SHALL take priority over every other event, including a commit or a rejection on the same edge.
REQ-027 Reset asserted mid-confirmation SHALL discard the pending change; after release the confirmation restarts from ESTAVEL.
REQ-028 The first falling edge after reset deasserts SHALL perform normal sampling.

Verification (DEBOUNCE=4)
REQ-029 Reset, then head_raw held at 1 from edge 1: head=1 after edge 6; atualizado=1 for the cycle after edge 6 only; glitches=0.
REQ-030 left_raw=1 for exactly 2 edges, then 0: left stays 0; glitches=1; atualizado never pulses.
REQ-031 head_raw and left_raw rise on the same edge and then hold: both outputs rise on edge 6 together; atualizado gives one pulse.
REQ-032 head_raw=1 held; reset=1 asserted at edge 4 for one cycle, then released: head=0 through reset; head rises only 6 edges after sampling resumes.
REQ-033 Force glitches to 254 via 127 double glitches on both channels, then one more double glitch: glitches=255; further glitches keep it at 255.
REQ-034 head=1 established, then head_raw=0 held: head falls 6 edges after the change, with one atualizado pulse.
